// File: rtl/mat_pkg.sv
// Shared definitions for the matrix operation sequencer: op codes, error codes,
// dimension limit and FSM state encoding.
package mat_pkg;

  localparam int MAX_DIM = 5;

  localparam logic [2:0] OP_T = 3'b000;
  localparam logic [2:0] OP_A = 3'b001;
  localparam logic [2:0] OP_B = 3'b010;
  localparam logic [2:0] OP_C = 3'b011;
  localparam logic [2:0] OP_J = 3'b100;

  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_MISMATCH = 3'b001;
  localparam logic [2:0] ERR_RANGE    = 3'b010;
  localparam logic [2:0] ERR_UNSUP    = 3'b011;
  localparam logic [2:0] ERR_ABORT    = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ_A,
    READ_B,
    ACC,
    WRITE,
    DONE
  } state_t;

  function automatic logic dim_ok(input logic [3:0] d);
    return (d != 4'd0) && (d <= 4'(MAX_DIM));
  endfunction

endpackage

// File: rtl/mat_addr_calc.sv
// Row-major element address: base + row*cols + col, wrapping modulo 256.
module mat_addr_calc
  import mat_pkg::*;
(
  input  logic [7:0] base,
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  logic [3:0] cols,
  output logic [7:0] addr
);

  assign addr = base + (8'(row) * 8'(cols)) + 8'(col);

endmodule

// File: rtl/mat_op_sequencer.sv
// Sequences element-wise matrix operations (transpose, add, scalar, multiply)
// over a single read/write storage port, one result element at a time.
module mat_op_sequencer
  import mat_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  op,
  input  logic [3:0]  scalar,
  input  logic [3:0]  a_m,
  input  logic [3:0]  a_n,
  input  logic [3:0]  b_m,
  input  logic [3:0]  b_n,
  input  logic [7:0]  a_base,
  input  logic [7:0]  b_base,
  input  logic [7:0]  r_base,
  output logic        rd_en,
  output logic [7:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [19:0] wr_data,
  output logic        busy,
  output logic        op_done,
  output logic [2:0]  error_type,
  output logic [3:0]  result_m,
  output logic [3:0]  result_n
);

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [3:0]  scalar_q, a_m_q, a_n_q, b_m_q, b_n_q;
  logic [7:0]  a_base_q, b_base_q, r_base_q;
  logic [3:0]  i_q, j_q, k_q, i_nxt, j_nxt, k_nxt;
  logic [7:0]  a_reg;
  logic [19:0] acc, sum;
  logic [2:0]  chk_err;
  logic        b_used, last_col, last_row, last_k;
  logic [3:0]  col_last;

  logic [7:0]  rd_base, wr_base, rd_calc, wr_calc;
  logic [3:0]  rd_row, rd_col, rd_cols, wr_row, wr_col, wr_cols;

  assign col_last = (op_q == OP_C) ? b_n_q : a_n_q;
  assign last_col = (j_q == col_last - 4'd1);
  assign last_row = (i_q == a_m_q - 4'd1);
  assign last_k   = (k_q == a_n_q - 4'd1);

  // Operand validation on the latched request, range errors taking precedence.
  always_comb begin
    chk_err = ERR_NONE;
    b_used  = (op_q == OP_A) || (op_q == OP_C);
    if (!dim_ok(a_m_q) || !dim_ok(a_n_q) ||
        (b_used && (!dim_ok(b_m_q) || !dim_ok(b_n_q))))
      chk_err = ERR_RANGE;
    else if (op_q > OP_C)
      chk_err = ERR_UNSUP;
    else if ((op_q == OP_A) && ((a_m_q != b_m_q) || (a_n_q != b_n_q)))
      chk_err = ERR_MISMATCH;
    else if ((op_q == OP_C) && (a_n_q != b_m_q))
      chk_err = ERR_MISMATCH;
  end

  // Next state and next element indices; abort overrides everything outside IDLE.
  always_comb begin
    state_nxt = state;
    i_nxt     = i_q;
    j_nxt     = j_q;
    k_nxt     = k_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CHECK;
          i_nxt     = 4'd0;
          j_nxt     = 4'd0;
          k_nxt     = 4'd0;
        end
      end
      CHECK:  state_nxt = (chk_err != ERR_NONE) ? DONE : READ_A;
      READ_A: state_nxt = ((op_q == OP_A) || (op_q == OP_C)) ? READ_B : ACC;
      READ_B: state_nxt = ACC;
      ACC: begin
        if ((op_q == OP_C) && !last_k) begin
          k_nxt     = k_q + 4'd1;
          state_nxt = READ_A;
        end else begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        k_nxt = 4'd0;
        if (last_col) begin
          if (last_row) begin
            state_nxt = DONE;
          end else begin
            j_nxt     = 4'd0;
            i_nxt     = i_q + 4'd1;
            state_nxt = READ_A;
          end
        end else begin
          j_nxt     = j_q + 4'd1;
          state_nxt = READ_A;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE))
      state_nxt = IDLE;
  end

  // Read addresses are formed from the indices of the state being entered.
  always_comb begin
    rd_base = a_base_q;
    rd_row  = i_nxt;
    rd_col  = (op_q == OP_C) ? k_nxt : j_nxt;
    rd_cols = a_n_q;
    if (state_nxt == READ_B) begin
      rd_base = b_base_q;
      rd_row  = (op_q == OP_C) ? k_nxt : i_nxt;
      rd_col  = j_nxt;
      rd_cols = b_n_q;
    end
  end

  always_comb begin
    wr_base = r_base_q;
    wr_row  = i_q;
    wr_col  = j_q;
    wr_cols = col_last;
    if (op_q == OP_T) begin
      wr_row  = j_q;
      wr_col  = i_q;
      wr_cols = a_m_q;
    end
  end

  mat_addr_calc u_rd_addr (
    .base (rd_base),
    .row  (rd_row),
    .col  (rd_col),
    .cols (rd_cols),
    .addr (rd_calc)
  );

  mat_addr_calc u_wr_addr (
    .base (wr_base),
    .row  (wr_row),
    .col  (wr_col),
    .cols (wr_cols),
    .addr (wr_calc)
  );

  // In ACC rd_data holds the last operand read; a_reg holds the earlier one.
  always_comb begin
    sum = 20'd0;
    case (op_q)
      OP_T:    sum = 20'(rd_data);
      OP_B:    sum = 20'(rd_data) * 20'(scalar_q);
      OP_A:    sum = 20'(a_reg) + 20'(rd_data);
      default: sum = acc + (20'(a_reg) * 20'(rd_data));
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      i_q        <= 4'd0;
      j_q        <= 4'd0;
      k_q        <= 4'd0;
      op_q       <= 3'd0;
      scalar_q   <= 4'd0;
      a_m_q      <= 4'd0;
      a_n_q      <= 4'd0;
      b_m_q      <= 4'd0;
      b_n_q      <= 4'd0;
      a_base_q   <= 8'd0;
      b_base_q   <= 8'd0;
      r_base_q   <= 8'd0;
      a_reg      <= 8'd0;
      acc        <= 20'd0;
      busy       <= 1'b0;
      op_done    <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= 8'd0;
      wr_en      <= 1'b0;
      wr_addr    <= 8'd0;
      wr_data    <= 20'd0;
      error_type <= ERR_NONE;
      result_m   <= 4'd0;
      result_n   <= 4'd0;
    end else begin
      state   <= state_nxt;
      i_q     <= i_nxt;
      j_q     <= j_nxt;
      k_q     <= k_nxt;
      busy    <= (state_nxt != IDLE);
      op_done <= (state_nxt == DONE);
      rd_en   <= (state_nxt == READ_A) || (state_nxt == READ_B);
      wr_en   <= (state_nxt == WRITE);

      if ((state_nxt == READ_A) || (state_nxt == READ_B))
        rd_addr <= rd_calc;
      if (state_nxt == WRITE) begin
        wr_addr <= wr_calc;
        wr_data <= sum;
      end

      if ((state == IDLE) && start) begin
        op_q     <= op;
        scalar_q <= scalar;
        a_m_q    <= a_m;
        a_n_q    <= a_n;
        b_m_q    <= b_m;
        b_n_q    <= b_n;
        a_base_q <= a_base;
        b_base_q <= b_base;
        r_base_q <= r_base;
      end

      if (state == READ_B)
        a_reg <= rd_data;
      if (state == ACC)
        acc <= sum;
      else if ((state == CHECK) || (state == WRITE))
        acc <= 20'd0;

      if (state_nxt == CHECK)
        error_type <= ERR_NONE;
      else if (abort && (state != IDLE))
        error_type <= ERR_ABORT;
      else if ((state == CHECK) && (state_nxt == DONE))
        error_type <= chk_err;

      // Only the error path reaches DONE straight from CHECK.
      if (state_nxt == DONE) begin
        if (state == CHECK) begin
          result_m <= 4'd0;
          result_n <= 4'd0;
        end else if (op_q == OP_T) begin
          result_m <= a_n_q;
          result_n <= a_m_q;
        end else begin
          result_m <= a_m_q;
          result_n <= col_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_mat_op_sequencer.sv
// Randomised and directed bench for mat_op_sequencer against a matrix-level model.
module tb_mat_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [3:0]  scalar = 4'd0;
  logic [3:0]  a_m = 4'd1, a_n = 4'd1, b_m = 4'd1, b_n = 4'd1;
  logic [7:0]  a_base = 8'd0, b_base = 8'd0, r_base = 8'd0;
  logic        rd_en, wr_en, busy, op_done;
  logic [7:0]  rd_addr, wr_addr;
  logic [7:0]  rd_data = 8'd0;
  logic [19:0] wr_data;
  logic [2:0]  error_type;
  logic [3:0]  result_m, result_n;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt = 0;
  logic [7:0]  mem [256];
  logic [27:0] wq [$];
  logic [27:0] exp_q [$];
  int exp_err, exp_rm, exp_rn, exp_e, exp_reads;

  mat_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op(op),
    .scalar(scalar), .a_m(a_m), .a_n(a_n), .b_m(b_m), .b_n(b_n),
    .a_base(a_base), .b_base(b_base), .r_base(r_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .op_done(op_done), .error_type(error_type),
    .result_m(result_m), .result_n(result_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Storage responds one cycle after a read request.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (rd_en) rd_cnt++;
  end

  task automatic check_output(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int rd_mem(input int base, input int row, input int cols, input int col);
    return int'(mem[(base + row * cols + col) & 255]);
  endfunction

  function automatic logic dim_good(input int d);
    return (d >= 1) && (d <= 5);
  endfunction

  // Reference: computes the result matrix directly from the operand matrices.
  task automatic build_model();
    int am, an, bm, bn, cols, v, addr;
    logic b_used;
    am = int'(a_m); an = int'(a_n); bm = int'(b_m); bn = int'(b_n);
    b_used = (op == 3'd1) || (op == 3'd3);
    exp_q.delete();
    exp_err = 0; exp_rm = 0; exp_rn = 0; exp_e = 0; exp_reads = 0;
    if (!dim_good(am) || !dim_good(an) || (b_used && (!dim_good(bm) || !dim_good(bn))))
      exp_err = 2;
    else if (op > 3'd3)
      exp_err = 3;
    else if ((op == 3'd1) && ((am != bm) || (an != bn)))
      exp_err = 1;
    else if ((op == 3'd3) && (an != bm))
      exp_err = 1;
    if (exp_err != 0) return;
    cols = (op == 3'd3) ? bn : an;
    exp_rm = (op == 3'd0) ? an : am;
    exp_rn = (op == 3'd0) ? am : cols;
    for (int i = 0; i < am; i++) begin
      for (int j = 0; j < cols; j++) begin
        addr = (int'(r_base) + i * cols + j) & 255;
        case (op)
          3'd0: begin
            v = rd_mem(int'(a_base), i, an, j);
            addr = (int'(r_base) + j * am + i) & 255;
            exp_e += 3; exp_reads += 1;
          end
          3'd1: begin
            v = rd_mem(int'(a_base), i, an, j) + rd_mem(int'(b_base), i, bn, j);
            exp_e += 4; exp_reads += 2;
          end
          3'd2: begin
            v = rd_mem(int'(a_base), i, an, j) * int'(scalar);
            exp_e += 3; exp_reads += 1;
          end
          default: begin
            v = 0;
            for (int k = 0; k < an; k++)
              v += rd_mem(int'(a_base), i, an, k) * rd_mem(int'(b_base), k, bn, j);
            exp_e += 3 * an + 1; exp_reads += 2 * an;
          end
        endcase
        exp_q.push_back({8'(addr), 20'(v)});
      end
    end
  endtask

  task automatic apply_stimulus(output int t0);
    @(negedge clk);
    wq.delete();
    rd_cnt = 0;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_and_check(input string name, input logic inject);
    int t0, seen, done_cyc;
    build_model();
    apply_stimulus(t0);
    check_output({name, "_busy"}, int'(busy), 1);
    seen = 0;
    done_cyc = 0;
    for (int n = 0; n < 600 && seen == 0; n++) begin
      if (op_done) begin
        seen = 1;
        done_cyc = cyc;
      end else begin
        if (inject && cyc == t0 + 5) begin
          start = 1'b1; op = 3'd0; a_m = 4'd1; a_n = 4'd1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (seen == 0) begin
      check_output({name, "_op_done_timeout"}, 0, 1);
      return;
    end
    check_output({name, "_latency"}, done_cyc - t0, 2 + exp_e);
    check_output({name, "_err"}, int'(error_type), exp_err);
    check_output({name, "_rm"}, int'(result_m), exp_rm);
    check_output({name, "_rn"}, int'(result_n), exp_rn);
    check_output({name, "_nwr"}, wq.size(), exp_q.size());
    check_output({name, "_nrd"}, rd_cnt, exp_reads);
    for (int w = 0; w < wq.size() && w < exp_q.size(); w++) begin
      check_output({name, "_waddr"}, int'(wq[w][27:20]), int'(exp_q[w][27:20]));
      check_output({name, "_wdata"}, int'(wq[w][19:0]), int'(exp_q[w][19:0]));
    end
    @(negedge clk);
    check_output({name, "_done_pulse"}, int'(op_done), 0);
    check_output({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic set_op(input logic [2:0] o, input int am, input int an, input int bm,
                        input int bn, input int ab, input int bb, input int rb, input int sc);
    op = o; a_m = 4'(am); a_n = 4'(an); b_m = 4'(bm); b_n = 4'(bn);
    a_base = 8'(ab); b_base = 8'(bb); r_base = 8'(rb); scalar = 4'(sc);
  endtask

  function automatic logic [3:0] rnd_dim();
    int p;
    p = $urandom_range(0, 19);
    if (p == 0) return 4'd0;
    if (p == 1) return 4'($urandom_range(6, 15));
    return 4'($urandom_range(1, 5));
  endfunction

  task automatic check_all_reset(input string name);
    check_output({name, "_busy"}, int'(busy), 0);
    check_output({name, "_done"}, int'(op_done), 0);
    check_output({name, "_rd_en"}, int'(rd_en), 0);
    check_output({name, "_wr_en"}, int'(wr_en), 0);
    check_output({name, "_rd_addr"}, int'(rd_addr), 0);
    check_output({name, "_wr_addr"}, int'(wr_addr), 0);
    check_output({name, "_wr_data"}, int'(wr_data), 0);
    check_output({name, "_err"}, int'(error_type), 0);
    check_output({name, "_rm"}, int'(result_m), 0);
    check_output({name, "_rn"}, int'(result_n), 0);
  endtask

  initial begin
    int t0, seen;
    for (int a = 0; a < 256; a++) mem[a] = 8'd0;
    #23;
    check_all_reset("reset");
    rst_n = 1'b1;

    // Add 2x2, with a stray start while busy.
    for (int e = 0; e < 8; e++) mem[e] = 8'(e + 1);
    set_op(3'd1, 2, 2, 2, 2, 0, 4, 8, 0);
    run_and_check("add", 1'b1);

    // Multiply 2x3 by 3x2.
    for (int e = 0; e < 12; e++) mem[e] = 8'(e + 1);
    set_op(3'd3, 2, 3, 3, 2, 0, 6, 20, 0);
    run_and_check("mul", 1'b0);

    set_op(3'd0, 2, 3, 0, 0, 0, 0, 40, 0);
    run_and_check("transpose", 1'b0);
    set_op(3'd2, 2, 3, 0, 0, 0, 0, 40, 3);
    run_and_check("scalar", 1'b0);

    set_op(3'd1, 2, 2, 2, 3, 0, 4, 8, 0);
    run_and_check("err_mismatch", 1'b0);
    set_op(3'd0, 6, 2, 1, 1, 0, 4, 8, 0);
    run_and_check("err_range", 1'b0);
    set_op(3'd4, 2, 2, 2, 2, 0, 4, 8, 0);
    run_and_check("err_unsup", 1'b0);

    for (int e = 0; e < 50; e++) mem[e] = 8'd255;
    set_op(3'd3, 5, 5, 5, 5, 0, 25, 100, 0);
    run_and_check("mul_max", 1'b0);

    for (int e = 0; e < 9; e++) mem[(250 + e) & 255] = 8'(10 + e);
    set_op(3'd0, 3, 3, 0, 0, 250, 0, 100, 0);
    run_and_check("wrap_read", 1'b0);
    set_op(3'd2, 3, 3, 0, 0, 250, 0, 252, 15);
    run_and_check("wrap_write", 1'b0);

    // Abort a multiply at T+10.
    for (int e = 0; e < 12; e++) mem[e] = 8'(e + 1);
    set_op(3'd3, 2, 3, 3, 2, 0, 6, 20, 0);
    apply_stimulus(t0);
    while (cyc < t0 + 10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_err", int'(error_type), 4);
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      if (op_done) seen = 1;
      @(negedge clk);
    end
    check_output("abort_no_done", seen, 0);
    check_output("abort_no_wr", wq.size(), 0);

    // Asynchronous reset in the middle of a multiply.
    set_op(3'd3, 3, 3, 3, 3, 0, 9, 30, 0);
    apply_stimulus(t0);
    while (cyc < t0 + 8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 24; r++) begin
      logic [2:0] ro;
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
      ro = 3'($urandom_range(0, 3));
      op = ro;
      a_m = rnd_dim(); a_n = rnd_dim();
      b_m = ($urandom_range(0, 3) != 0) ? ((ro == 3'd3) ? a_n : a_m) : rnd_dim();
      b_n = ($urandom_range(0, 3) != 0 && ro == 3'd1) ? a_n : rnd_dim();
      a_base = 8'($urandom); b_base = 8'($urandom); r_base = 8'($urandom);
      scalar = 4'($urandom);
      run_and_check($sformatf("rnd%0d", r), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
